hazard_ctrl: RTL and testbench

Pipeline control unit for the five-stage RV32I core. Drives the per-register hold/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write-hold. It resolves three hazard classes:
- load-use stalls;
- taken-branch flushes resolved in MEM;
- multi-cycle data-memory waits, with timeout fault.

It also keeps saturating stall and flush counters for performance analysis.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_if.sv | 28 ++
 rtl/hazard_ctrl_load_use_detect.sv | 30 +++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode constants, FSM state type and pipeline-register bit indices
// for the RV32I hazard control unit.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FAULT
  } state_e;

  localparam int unsigned IDX_IF_ID  = 0;
  localparam int unsigned IDX_ID_EX  = 1;
  localparam int unsigned IDX_EX_MEM = 2;
  localparam int unsigned IDX_MEM_WB = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl; the control unit takes the
// slave view, the pipeline (or a bench) drives through the master view.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      id_inst;
  logic [31:0]      ex_inst;
  logic             ex_mem_read;
  logic             mem_pcsrc;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_hold;
  logic [3:0]       hold;
  logic [3:0]       flush;
  logic             fault;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_inst, ex_inst, ex_mem_read, mem_pcsrc, mem_access, dmem_ready,
    input  pc_hold, hold, flush, fault, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_inst, ex_inst, ex_mem_read, mem_pcsrc, mem_access, dmem_ready,
    output pc_hold, hold, flush, fault, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: flags when the ID instruction reads the
// destination of a load currently in EX.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] id_inst_i,
  input  logic [31:0] ex_inst_i,
  input  logic        ex_mem_read_i,
  output logic        hazard_o
);
  logic [4:0] rd, rs1, rs2;
  logic [6:0] opcode;
  logic       rs1_used, rs2_used;
  logic       unused_bits;

  assign rd     = ex_inst_i[11:7];
  assign rs1    = id_inst_i[19:15];
  assign rs2    = id_inst_i[24:20];
  assign opcode = id_inst_i[6:0];

  // Only the register fields and the opcode take part in detection.
  assign unused_bits = ^{ex_inst_i[31:12], ex_inst_i[6:0],
                         id_inst_i[31:25], id_inst_i[14:7]};

  assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign rs2_used = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);

  assign hazard_o = ex_mem_read_i && (rd != '0) &&
                    ((rs1_used && rd == rs1) || (rs2_used && rd == rs2));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, MEM-stage branch flushes,
// data-memory wait holds with timeout fault, and saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input logic       clk,
  input logic       rst,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned    WCW       = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             lu_haz, run_rules, br_take;
  logic             pc_hold, fault;
  logic [3:0]       hold, flush;

  load_use_detect u_lud (
    .id_inst_i     (bus.id_inst),
    .ex_inst_i     (bus.ex_inst),
    .ex_mem_read_i (bus.ex_mem_read),
    .hazard_o      (lu_haz)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pc_hold   = 1'b0;
    hold      = '0;
    flush     = '0;
    fault     = 1'b0;
    br_take   = 1'b0;
    run_rules = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.mem_access && !bus.dmem_ready) begin
          pc_hold = 1'b1;
          hold    = 4'b0111;
          flush   = 4'b1000;
          state_d = MEM_WAIT;
          wait_d  = WCW'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          pc_hold = 1'b1;
          hold    = 4'b0111;
          flush   = 4'b1000;
          if (wait_q == WAIT_LAST) state_d = FAULT;
          else                     wait_d  = wait_q + WCW'(1);
        end else begin
          run_rules = 1'b1;
          state_d   = RUN;
          wait_d    = '0;
        end
      end
      FAULT: begin
        pc_hold = 1'b1;
        hold    = 4'b0111;
        flush   = 4'b1000;
        fault   = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Branch outranks load-use: the dependent instruction is flushed anyway.
    if (run_rules) begin
      if (bus.mem_pcsrc) begin
        br_take               = 1'b1;
        flush[IDX_IF_ID]      = 1'b1;
        flush[IDX_ID_EX]      = 1'b1;
        flush[IDX_EX_MEM]     = 1'b1;
      end else if (lu_haz) begin
        pc_hold               = 1'b1;
        hold[IDX_IF_ID]       = 1'b1;
        flush[IDX_ID_EX]      = 1'b1;
      end
    end

    if (rst) begin
      pc_hold = 1'b1;
      hold    = '0;
      flush   = '1;
      fault   = 1'b0;
      br_take = 1'b0;
    end

    stall_d = (pc_hold && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (br_take && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_hold   = pc_hold;
  assign bus.hold      = hold;
  assign bus.flush     = flush;
  assign bus.fault     = fault;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expected
// outputs per cycle, a monitor pops and compares them mid-cycle.
module tb_hazard_ctrl;
  localparam int unsigned CW = 4;

  // {pc_hold, hold[3:0], flush[3:0], fault}
  localparam logic [9:0] E_IDLE = 10'b0_0000_0000_0;
  localparam logic [9:0] E_LU   = 10'b1_0001_0010_0;
  localparam logic [9:0] E_BR   = 10'b0_0000_0111_0;
  localparam logic [9:0] E_MW   = 10'b1_0111_1000_0;
  localparam logic [9:0] E_FT   = 10'b1_0111_1000_1;
  localparam logic [9:0] E_RST  = 10'b1_0000_1111_0;

  localparam logic [31:0] LW_X5    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] LW_X0    = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_655  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] ADD_600  = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] LUI_X5   = 32'h000282B7; // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] ADDI_IMM = 32'h00508313; // addi x6,x1,5 (rs2 field = 5)
  localparam logic [31:0] SW_X5    = 32'h00512023; // sw   x5,0(x2)
  localparam logic [31:0] NOP      = 32'h00000013;

  typedef struct {
    string      name;
    logic [9:0] outs;
    logic       ck;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string nm, input logic [31:0] idi, input logic [31:0] exi,
                     input logic emr, input logic pcs, input logic acc, input logic rdy,
                     input logic r, input logic [9:0] eo, input logic ck,
                     input logic [3:0] es, input logic [3:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.id_inst     = idi;
    bus.ex_inst     = exi;
    bus.ex_mem_read = emr;
    bus.mem_pcsrc   = pcs;
    bus.mem_access  = acc;
    bus.dmem_ready  = rdy;
    e.name = nm; e.outs = eo; e.ck = ck; e.sc = es; e.fc = ef;
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [9:0] eo,
                      input logic [3:0] es, input logic [3:0] ef);
    cyc(nm, NOP, NOP, 0, 0, 0, 0, 0, eo, 1, es, ef);
  endtask

  initial begin : monitor
    exp_t e;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e   = q.pop_front();
        got = {bus.pc_hold, bus.hold, bus.flush, bus.fault};
        checks++;
        if (got !== e.outs) begin
          failures++;
          $display("FAIL %s outs {pc_hold,hold,flush,fault} got=%b exp=%b", e.name, got, e.outs);
        end
        if (e.ck) begin
          checks++;
          if (bus.stall_cnt !== e.sc || bus.flush_cnt !== e.fc) begin
            failures++;
            $display("FAIL %s counters stall/flush got=%0d/%0d exp=%0d/%0d",
                     e.name, bus.stall_cnt, bus.flush_cnt, e.sc, e.fc);
          end
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    bus.id_inst = NOP; bus.ex_inst = NOP; bus.ex_mem_read = 0;
    bus.mem_pcsrc = 0; bus.mem_access = 0; bus.dmem_ready = 0;

    cyc("rst0", NOP, NOP, 0, 0, 0, 0, 1, E_RST, 0, 0, 0);
    cyc("rst1", NOP, NOP, 0, 0, 0, 0, 1, E_RST, 1, 0, 0);
    idle("idle", E_IDLE, 0, 0);

    // load-use variants
    cyc("lu_rs1",   ADD_655,  LW_X5, 1, 0, 0, 0, 0, E_LU,   1, 0, 0);
    idle("lu_clear", E_IDLE, 1, 0);
    cyc("lu_rd0",   ADD_600,  LW_X0, 1, 0, 0, 0, 0, E_IDLE, 1, 1, 0);
    cyc("lu_lui",   LUI_X5,   LW_X5, 1, 0, 0, 0, 0, E_IDLE, 1, 1, 0);
    cyc("lu_itype", ADDI_IMM, LW_X5, 1, 0, 0, 0, 0, E_IDLE, 1, 1, 0);
    cyc("lu_rs2",   SW_X5,    LW_X5, 1, 0, 0, 0, 0, E_LU,   1, 1, 0);
    cyc("lu_noload", ADD_655, LW_X5, 0, 0, 0, 0, 0, E_IDLE, 1, 2, 0);

    // branches
    cyc("br",    NOP,     NOP,   0, 1, 0, 0, 0, E_BR, 1, 2, 0);
    cyc("br_lu", ADD_655, LW_X5, 1, 1, 0, 0, 0, E_BR, 1, 2, 1);
    idle("br_after", E_IDLE, 2, 2);

    // memory: zero-wait, then 3-cycle wait with branch pending
    cyc("mem_rdy", NOP, NOP, 0, 0, 1, 1, 0, E_IDLE, 1, 2, 2);
    cyc("mw1", NOP, NOP, 0, 1, 1, 0, 0, E_MW, 1, 2, 2);
    cyc("mw2", NOP, NOP, 0, 1, 1, 0, 0, E_MW, 1, 3, 2);
    cyc("mw3", NOP, NOP, 0, 1, 1, 0, 0, E_MW, 1, 4, 2);
    cyc("mw_done_br", NOP, NOP, 0, 1, 1, 1, 0, E_BR, 1, 5, 2);
    idle("mw_after", E_IDLE, 5, 3);

    // timeout after 4 wait cycles, fault is sticky
    cyc("to1", NOP, NOP, 0, 0, 1, 0, 0, E_MW, 1, 5, 3);
    cyc("to2", NOP, NOP, 0, 0, 1, 0, 0, E_MW, 1, 6, 3);
    cyc("to3", NOP, NOP, 0, 0, 1, 0, 0, E_MW, 1, 7, 3);
    cyc("to4", NOP, NOP, 0, 0, 1, 0, 0, E_MW, 1, 8, 3);
    cyc("fault1", NOP, NOP, 0, 0, 1, 0, 0, E_FT, 1, 9, 3);
    cyc("fault_rdy", NOP, NOP, 0, 1, 1, 1, 0, E_FT, 1, 10, 3);
    cyc("fault3", NOP, NOP, 0, 0, 0, 0, 0, E_FT, 1, 11, 3);
    cyc("fault_rst", NOP, NOP, 0, 0, 0, 0, 1, E_RST, 1, 12, 3);
    idle("post_rst", E_IDLE, 0, 0);

    // reset in the second cycle of a wait
    cyc("rw1", NOP, NOP, 0, 0, 1, 0, 0, E_MW, 1, 0, 0);
    cyc("rw_rst", NOP, NOP, 0, 0, 1, 0, 1, E_RST, 1, 1, 0);
    idle("rw_run", E_IDLE, 0, 0);

    // stall counter saturation
    for (int i = 0; i < 20; i++)
      cyc("sat", ADD_655, LW_X5, 1, 0, 0, 0, 0, E_LU, 1, (i < 15) ? 4'(i) : 4'd15, 0);
    idle("sat_hold", E_IDLE, 15, 0);
    idle("sat_hold2", E_IDLE, 15, 0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain queue got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
